delay_arbiter: RTL

- Shares one delay_gen millisecond timer between NUM_REQ independent requesters, e.g. display init sequencer, refresh controller and UART pacing.
- Arbitrates round-robin, drives the delay_gen delay_ms/delay_en handshake, and returns a one-cycle ack to the winning requester when its delay completes.
- Sits between the requester FSMs and a single delay_gen instance.

---
 rtl/delay_arbiter_if.sv | 35 +++
 rtl/delay_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/delay_arbiter_if.sv
// delay_arbiter_if: handshake bundle between the requesters, the arbiter and
// a single delay_gen timer.
//   req       requester level requests, one bit per requester
//   req_ms    packed per-requester delay values, requester i at [i*MS_W +: MS_W]
//   ack       one-hot one-cycle completion pulse to the served requester
//   grant_id  index of the current or most recent grantee
//   busy      a delay is in flight
//   delay_ms  latched delay value to delay_gen
//   delay_en  enable to delay_gen
//   delay_fin completion flag from delay_gen
// slave modport: arbiter side. master modport: requester/timer side.
interface delay_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MS_W    = 12,
  parameter int unsigned IDX_W   = 2
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*MS_W-1:0] req_ms;
  logic [NUM_REQ-1:0]      ack;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;
  logic [MS_W-1:0]         delay_ms;
  logic                    delay_en;
  logic                    delay_fin;

  modport slave (
    input  req, req_ms, delay_fin,
    output ack, grant_id, busy, delay_ms, delay_en
  );

  modport master (
    output req, req_ms, delay_fin,
    input  ack, grant_id, busy, delay_ms, delay_en
  );
endinterface

// File: rtl/delay_arbiter.sv
// delay_arbiter: shares one delay_gen millisecond timer between NUM_REQ
// requesters. Round-robin arbitration starting after the most recent grantee,
// latches the winner's delay value, drives delay_en until delay_fin or an
// abort (winner drops req), then spends one RELEASE cycle with delay_en low
// before returning to IDLE. A completion returns a one-cycle one-hot ack.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  delay_arbiter_if.slave (req, req_ms, delay_fin in;
//        ack, grant_id, busy, delay_ms, delay_en out), all outputs registered
module delay_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MS_W    = 12,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  delay_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [MS_W-1:0]    delay_ms_q, delay_ms_d;
  logic               delay_en_q, delay_en_d;
  logic               busy_q, busy_d;

  // round-robin winner search results
  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic [MS_W-1:0]    win_ms;

  // Scan starts one past the last grantee so the just-served index comes last.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    win_idx  = grant_id_q;
    win_ms   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(grant_id_q) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && bus.req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
        win_ms  = MS_W'(bus.req_ms >> (cand * MS_W));
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    delay_ms_d = delay_ms_q;
    delay_en_d = delay_en_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        delay_en_d = 1'b0;
        busy_d     = 1'b0;
        if (found) begin
          grant_id_d = win_idx;
          delay_ms_d = win_ms;
          delay_en_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end

      RUN: begin
        // completion takes precedence over a simultaneous request drop
        if (bus.delay_fin) begin
          delay_en_d = 1'b0;
          ack_d      = NUM_REQ'(1) << grant_id_q;
          state_d    = RELEASE;
        end else if (!bus.req[grant_id_q]) begin
          delay_en_d = 1'b0;
          state_d    = RELEASE;
        end
      end

      RELEASE: begin
        delay_en_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        delay_en_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      grant_id_q <= IDX_W'(NUM_REQ - 1);
      delay_ms_q <= '0;
      delay_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      delay_ms_q <= delay_ms_d;
      delay_en_q <= delay_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_id_q;
  assign bus.delay_ms = delay_ms_q;
  assign bus.delay_en = delay_en_q;
  assign bus.busy     = busy_q;

endmodule
